// File: rtl/burst_sched.sv
// burst_sched: schedules a burst of frames with idle gaps, latched config and abort handling.
// Define BURST_SCHED_TIMEOUT_EN to enable the frame_done watchdog (timeout_err).
`timescale 1ns/1ps
module burst_sched #(
   parameter int GAP_W          = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_pulse,
   input  logic             stop,
   input  logic [7:0]       cfg_burst_count,
   input  logic [GAP_W-1:0] cfg_gap_cycles,
   input  logic [3:0]       cfg_speed,
   input  logic             frame_done,
   output logic             send_enable,
   output logic [3:0]       speed_ctr,
   output logic             busy,
   output logic             done,
   output logic [7:0]       frame_idx,
   output logic             timeout_err
);
   typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_DONE, GAP, FINISH} state_t;
   state_t           state_q, state_d;
   logic [7:0]       count_q, count_d, idx_q, idx_d, idx_inc;
   logic [GAP_W-1:0] gap_q, gap_d, gcnt_q, gcnt_d;
   logic [3:0]       speed_q, speed_d;
   logic             stop_req_q, stop_req_d, stop_any, to_hit;
   assign idx_inc     = idx_q + 8'd1;
   assign stop_any    = stop_req_q | stop;
   assign send_enable = state_q == SEND;
   assign busy        = state_q != IDLE;
   assign done        = state_q == FINISH;
   assign speed_ctr   = speed_q;
   assign frame_idx   = idx_q;
`ifdef BURST_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_q, to_d;
   logic            terr_q, terr_d;
   // frame_done on the final watchdog cycle still counts as a normal completion
   assign to_hit      = state_q == WAIT_DONE && !frame_done && to_q == TO_W'(TIMEOUT_CYCLES - 1);
   assign to_d        = state_q == WAIT_DONE ? to_q + TO_W'(1) : '0;
   assign terr_d      = state_q == LOAD ? 1'b0 : terr_q | to_hit;
   assign timeout_err = terr_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_q   <= '0;
         terr_q <= 1'b0;
      end else begin
         to_q   <= to_d;
         terr_q <= terr_d;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT_CYCLES;
   assign to_hit         = 1'b0;
   assign timeout_err    = 1'b0;
`endif
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      gap_d      = gap_q;
      speed_d    = speed_q;
      idx_d      = idx_q;
      gcnt_d     = gcnt_q;
      stop_req_d = stop_req_q | (stop && state_q != IDLE);
      case (state_q)
         IDLE: if (start_pulse && !stop) state_d = LOAD;
         LOAD: begin
            count_d    = cfg_burst_count;
            gap_d      = cfg_gap_cycles;
            speed_d    = cfg_speed;
            idx_d      = '0;
            stop_req_d = stop;
            state_d    = SEND;
         end
         SEND: state_d = WAIT_DONE;
         WAIT_DONE: begin
            if (frame_done) begin
               idx_d   = idx_inc;
               gcnt_d  = gap_q;
               state_d = (stop_any || (count_q != 8'd0 && idx_inc == count_q)) ? FINISH :
                         (gap_q != '0) ? GAP : SEND;
            end else if (to_hit) begin
               state_d = FINISH;
            end
         end
         GAP: begin
            gcnt_d  = gcnt_q - GAP_W'(1);
            state_d = stop_any ? FINISH : (gcnt_q <= GAP_W'(1)) ? SEND : GAP;
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         count_q    <= '0;
         gap_q      <= '0;
         speed_q    <= '0;
         idx_q      <= '0;
         gcnt_q     <= '0;
         stop_req_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         gap_q      <= gap_d;
         speed_q    <= speed_d;
         idx_q      <= idx_d;
         gcnt_q     <= gcnt_d;
         stop_req_q <= stop_req_d;
      end
   end
endmodule

// File: tb/tb_burst_sched.sv
// tb_burst_sched: directed self-checking bench for burst_sched.
`timescale 1ns/1ps
module tb_burst_sched;
   logic        clk = 1'b0, rst = 1'b1, start_pulse = 1'b0, stop = 1'b0;
   logic [7:0]  cfg_burst_count = '0;
   logic [15:0] cfg_gap_cycles = '0;
   logic [3:0]  cfg_speed = '0;
   logic        frame_done, send_enable, busy, done, timeout_err;
   logic [3:0]  speed_ctr;
   logic [7:0]  frame_idx;
   logic        fd_auto = 1'b0, fd_man = 1'b0, fd_en = 1'b0;
   int          fd_delay = 1, cd = 0;
   int          checks = 0, errors = 0;
   int          cyc = 0, se_cnt = 0, done_cnt = 0, last_done_cyc = 0;
   int          se_cyc[$];

   assign frame_done = fd_auto | fd_man;

   burst_sched #(.GAP_W(16), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .start_pulse(start_pulse), .stop(stop),
      .cfg_burst_count(cfg_burst_count), .cfg_gap_cycles(cfg_gap_cycles),
      .cfg_speed(cfg_speed), .frame_done(frame_done), .send_enable(send_enable),
      .speed_ctr(speed_ctr), .busy(busy), .done(done), .frame_idx(frame_idx),
      .timeout_err(timeout_err)
   );

   always #50 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (send_enable) begin
         se_cnt <= se_cnt + 1;
         se_cyc.push_back(cyc);
      end
      if (done) begin
         done_cnt      <= done_cnt + 1;
         last_done_cyc <= cyc;
      end
   end

   // pattern-generator model: frame_done lands fd_delay cycles after the send_enable cycle
   always @(negedge clk) begin
      if (fd_auto) fd_auto = 1'b0;
      if (rst) cd = 0;
      if (cd > 0) begin
         cd = cd - 1;
         if (cd == 0) fd_auto = 1'b1;
      end
      if (send_enable && fd_en && !rst) cd = fd_delay;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [7:0] c, input logic [15:0] g, input logic [3:0] s);
      cfg_burst_count = c;
      cfg_gap_cycles  = g;
      cfg_speed       = s;
      start_pulse     = 1'b1;
      tick(1);
      start_pulse     = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick(1);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, budget);
      end
   endtask

   task automatic test_reset();
      tick(2);
      checks++;
      if ({send_enable, busy, done, frame_idx, speed_ctr, timeout_err} !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs: got se=%b busy=%b done=%b idx=%0d spd=%0d terr=%b, expected all 0",
                  send_enable, busy, done, frame_idx, speed_ctr, timeout_err);
      end
      rst = 1'b0;
      tick(2);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_burst();
      int b = se_cnt, d = done_cnt;
      fd_en = 1'b1;
      fd_delay = 21;
      start_run(8'd3, 16'd5, 4'd1);
      tick(2);
      cfg_burst_count = 8'd1;
      cfg_gap_cycles  = 16'd0;
      cfg_speed       = 4'd9;
      checks++;
      if (speed_ctr !== 4'd1) begin
         errors++;
         $display("FAIL burst_speed_latch: speed_ctr=%0d expected 1", speed_ctr);
      end
      wait_idle(300);
      checks++;
      if (se_cnt - b !== 3) begin
         errors++;
         $display("FAIL burst_sends: got %0d send_enable pulses, expected 3", se_cnt - b);
      end else begin
         checks++;
         if (se_cyc[b+1] - se_cyc[b] !== 27 || se_cyc[b+2] - se_cyc[b+1] !== 27) begin
            errors++;
            $display("FAIL burst_spacing: got %0d and %0d, expected 27 and 27",
                     se_cyc[b+1] - se_cyc[b], se_cyc[b+2] - se_cyc[b+1]);
         end
      end
      checks++;
      if (done_cnt - d !== 1) begin
         errors++;
         $display("FAIL burst_done: got %0d done strobes, expected 1", done_cnt - d);
      end
      checks++;
      if (frame_idx !== 8'd3 || speed_ctr !== 4'd1) begin
         errors++;
         $display("FAIL burst_hold: frame_idx=%0d speed_ctr=%0d, expected 3 and 1", frame_idx, speed_ctr);
      end
   endtask

   task automatic test_back_to_back();
      int b = se_cnt;
      fd_delay = 1;
      start_run(8'd3, 16'd0, 4'd4);
      wait_idle(100);
      checks++;
      if (se_cnt - b !== 3) begin
         errors++;
         $display("FAIL b2b_sends: got %0d, expected 3", se_cnt - b);
      end else begin
         checks++;
         if (se_cyc[b+1] - se_cyc[b] !== 2 || se_cyc[b+2] - se_cyc[b+1] !== 2) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d and %0d, expected 2 and 2",
                     se_cyc[b+1] - se_cyc[b], se_cyc[b+2] - se_cyc[b+1]);
         end
      end
      b = se_cnt;
      start_run(8'd1, 16'd7, 4'd4);
      wait_idle(100);
      checks++;
      if (se_cnt - b !== 1 || frame_idx !== 8'd1) begin
         errors++;
         $display("FAIL single_frame: sends=%0d frame_idx=%0d, expected 1 and 1", se_cnt - b, frame_idx);
      end
   endtask

   task automatic test_continuous_stop();
      int b = se_cnt, d = done_cnt, n = 0;
      fd_delay = 3;
      start_run(8'd0, 16'd0, 4'd2);
      while (se_cnt - b < 4 && n < 100) begin
         tick(1);
         n++;
      end
      checks++;
      if (se_cnt - b !== 4) begin
         errors++;
         $display("FAIL cont_reach4: got %0d sends, expected 4", se_cnt - b);
      end
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      wait_idle(100);
      tick(10);
      checks++;
      if (se_cnt - b !== 4) begin
         errors++;
         $display("FAIL cont_no5th: got %0d sends, expected 4", se_cnt - b);
      end
      checks++;
      if (done_cnt - d !== 1 || frame_idx !== 8'd4) begin
         errors++;
         $display("FAIL cont_done: done=%0d frame_idx=%0d, expected 1 and 4", done_cnt - d, frame_idx);
      end
   endtask

   task automatic test_start_stop();
      int b = se_cnt, d = done_cnt;
      cfg_burst_count = 8'd2;
      start_pulse = 1'b1;
      stop = 1'b1;
      tick(1);
      start_pulse = 1'b0;
      stop = 1'b0;
      tick(3);
      checks++;
      if (busy !== 1'b0 || se_cnt !== b) begin
         errors++;
         $display("FAIL start_stop_same: busy=%b sends=%0d, expected 0 and 0", busy, se_cnt - b);
      end
      fd_delay = 5;
      start_run(8'd2, 16'd0, 4'd3);
      tick(3);
      start_run(8'd9, 16'd4, 4'd7);
      tick(3);
      start_run(8'd9, 16'd4, 4'd7);
      wait_idle(100);
      checks++;
      if (se_cnt - b !== 2 || done_cnt - d !== 1 || frame_idx !== 8'd2 || speed_ctr !== 4'd3) begin
         errors++;
         $display("FAIL start_while_busy: sends=%0d done=%0d idx=%0d spd=%0d, expected 2 1 2 3",
                  se_cnt - b, done_cnt - d, frame_idx, speed_ctr);
      end
   endtask

   task automatic test_reset_mid();
      int d = done_cnt, b;
      fd_en = 1'b0;
      start_run(8'd2, 16'd0, 4'd5);
      tick(3);
      checks++;
      if (busy !== 1'b1 || speed_ctr !== 4'd5) begin
         errors++;
         $display("FAIL rst_mid_pre: busy=%b spd=%0d, expected 1 and 5", busy, speed_ctr);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({send_enable, busy, done, frame_idx, speed_ctr, timeout_err} !== 16'd0) begin
         errors++;
         $display("FAIL rst_mid_outputs: se=%b busy=%b done=%b idx=%0d spd=%0d terr=%b, expected all 0",
                  send_enable, busy, done, frame_idx, speed_ctr, timeout_err);
      end
      tick(1);
      rst = 1'b0;
      tick(2);
      checks++;
      if (done_cnt !== d) begin
         errors++;
         $display("FAIL rst_mid_nodone: got %0d done strobes, expected 0", done_cnt - d);
      end
      b = se_cnt;
      fd_en = 1'b1;
      fd_delay = 2;
      start_run(8'd1, 16'd0, 4'd2);
      wait_idle(100);
      checks++;
      if (se_cnt - b !== 1 || done_cnt - d !== 1 || frame_idx !== 8'd1 || speed_ctr !== 4'd2) begin
         errors++;
         $display("FAIL rst_mid_rerun: sends=%0d done=%0d idx=%0d spd=%0d, expected 1 1 1 2",
                  se_cnt - b, done_cnt - d, frame_idx, speed_ctr);
      end
   endtask

   task automatic test_ignore_fd();
      int b, n = 0;
      fd_man = 1'b1;
      tick(1);
      fd_man = 1'b0;
      tick(1);
      checks++;
      if (frame_idx !== 8'd1) begin
         errors++;
         $display("FAIL fd_in_idle: frame_idx=%0d expected 1", frame_idx);
      end
      b = se_cnt;
      fd_delay = 1;
      start_run(8'd2, 16'd10, 4'd0);
      while (se_cnt - b < 1 && n < 50) begin
         tick(1);
         n++;
      end
      tick(3);
      fd_man = 1'b1;
      tick(1);
      fd_man = 1'b0;
      tick(1);
      checks++;
      if (frame_idx !== 8'd1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL fd_in_gap: frame_idx=%0d busy=%b, expected 1 and 1", frame_idx, busy);
      end
      wait_idle(100);
      checks++;
      if (se_cnt - b !== 2 || frame_idx !== 8'd2) begin
         errors++;
         $display("FAIL fd_gap_run: sends=%0d idx=%0d, expected 2 and 2", se_cnt - b, frame_idx);
      end
   endtask

   task automatic test_timeout();
      int b = se_cnt, d = done_cnt;
      fd_en = 1'b0;
      start_run(8'd1, 16'd0, 4'd6);
`ifdef BURST_SCHED_TIMEOUT_EN
      wait_idle(100);
      checks++;
      if (timeout_err !== 1'b1 || done_cnt - d !== 1) begin
         errors++;
         $display("FAIL timeout_flag: terr=%b done=%0d, expected 1 and 1", timeout_err, done_cnt - d);
      end
      checks++;
      if (se_cnt - b !== 1 || last_done_cyc - se_cyc[b] !== 17) begin
         errors++;
         $display("FAIL timeout_len: sends=%0d send-to-done=%0d, expected 1 and 17",
                  se_cnt - b, last_done_cyc - se_cyc[b]);
      end
      tick(5);
      checks++;
      if (timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky: terr=%b expected 1", timeout_err);
      end
      fd_en = 1'b1;
      fd_delay = 2;
      start_run(8'd1, 16'd0, 4'd6);
      tick(1);
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear: terr=%b expected 0", timeout_err);
      end
      wait_idle(100);
`else
      tick(40);
      checks++;
      if (busy !== 1'b1 || timeout_err !== 1'b0 || done_cnt !== d) begin
         errors++;
         $display("FAIL no_timeout: busy=%b terr=%b done=%0d, expected 1 0 0", busy, timeout_err, done_cnt - d);
      end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      fd_en = 1'b1;
      tick(1);
`endif
   endtask

   initial begin
      test_reset();
      test_burst();
      test_back_to_back();
      test_continuous_stop();
      test_start_stop();
      test_reset_mid();
      test_ignore_fd();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
